if_fetch_unit: RTL and testbench

Fetch unit between the PC stage and decode. Drives the instruction-memory request for the current PC and holds the fetched instruction in the IF/ID pipeline register. Returns `is_cache_missed` to the PC stage while a fetch is outstanding. Handles decode stalls with a one-entry hold buffer and branch flushes, including flushes that arrive while a memory request is in flight.

---
 rtl/if_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: drives the imem request for the current PC and
// owns the IF/ID register, with a one-entry hold buffer and in-flight flush.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic             stall,
    input  logic             flush,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             is_cache_missed,
    output logic             if_id_valid,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc_plus4,
    output logic [31:0]      if_id_instr,
    output logic [CNT_W-1:0] fetch_stall_cycles
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      drop_addr_q, drop_addr_d;
    logic [31:0]      hold_pc_q, hold_pc_d;
    logic [31:0]      hold_instr_q, hold_instr_d;
    logic             valid_q, valid_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic [31:0]      id_pc4_q, id_pc4_d;
    logic [31:0]      id_instr_q, id_instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // RESET_PC only documents where the PC stage starts.
    logic unused_reset_pc;
    assign unused_reset_pc = ^RESET_PC;

    always_comb begin
        imem_req        = 1'b1;
        imem_addr       = pc;
        is_cache_missed = !imem_ack;
        unique case (state_q)
            FETCH: begin
                imem_req        = 1'b1;
                imem_addr       = pc;
                is_cache_missed = !imem_ack;
            end
            HOLD: begin
                imem_req        = 1'b0;
                imem_addr       = pc;
                is_cache_missed = 1'b0;
            end
            DROP: begin
                imem_req        = 1'b1;
                imem_addr       = drop_addr_q;
                is_cache_missed = 1'b1;
            end
            default: begin
                imem_req        = 1'b1;
                imem_addr       = pc;
                is_cache_missed = !imem_ack;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        drop_addr_d  = drop_addr_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        valid_d      = valid_q;
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;
        id_instr_d   = id_instr_q;
        cnt_d        = cnt_q;

        if (is_cache_missed && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        unique case (state_q)
            FETCH: begin
                if (flush) begin
                    valid_d    = 1'b0;
                    id_instr_d = 32'h0;
                    if (!imem_ack) begin
                        // Request is live on the bus; keep its address stable.
                        drop_addr_d = pc;
                        state_d     = DROP;
                    end
                end else if (imem_ack) begin
                    if (!stall) begin
                        valid_d    = 1'b1;
                        id_pc_d    = pc;
                        id_pc4_d   = pc + 32'd4;
                        id_instr_d = imem_rdata;
                    end else begin
                        hold_pc_d    = pc;
                        hold_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end
                end else if (!stall) begin
                    valid_d    = 1'b0;
                    id_instr_d = 32'h0;
                end
            end
            HOLD: begin
                if (flush) begin
                    valid_d    = 1'b0;
                    id_instr_d = 32'h0;
                    state_d    = FETCH;
                end else if (!stall) begin
                    valid_d    = 1'b1;
                    id_pc_d    = hold_pc_q;
                    id_pc4_d   = hold_pc_q + 32'd4;
                    id_instr_d = hold_instr_q;
                    state_d    = FETCH;
                end
            end
            DROP: begin
                if (flush) begin
                    valid_d    = 1'b0;
                    id_instr_d = 32'h0;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            drop_addr_q  <= 32'h0;
            hold_pc_q    <= 32'h0;
            hold_instr_q <= 32'h0;
            valid_q      <= 1'b0;
            id_pc_q      <= 32'h0;
            id_pc4_q     <= 32'h0;
            id_instr_q   <= 32'h0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            drop_addr_q  <= drop_addr_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            valid_q      <= valid_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
            id_instr_q   <= id_instr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign if_id_valid        = valid_q;
    assign if_id_pc           = id_pc_q;
    assign if_id_pc_plus4     = id_pc4_q;
    assign if_id_instr        = id_instr_q;
    assign fetch_stall_cycles = cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic
// against a behavioural model of the fetch/hold/drop rules.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        is_cache_missed;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic [15:0] fetch_stall_cycles;

    int errors = 0;
    int checks = 0;

    if_fetch_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .is_cache_missed(is_cache_missed),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
        .fetch_stall_cycles(fetch_stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic a, input logic [31:0] d,
                         input logic s, input logic f);
        pc = p; imem_ack = a; imem_rdata = d; stall = s; flush = f;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(32'h1234, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", if_id_valid); end
        checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", if_id_pc); end
        checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h want 0", if_id_pc_plus4); end
        checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", if_id_instr); end
        checks++; if (fetch_stall_cycles !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h want 0", fetch_stall_cycles); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h1234) begin errors++; $display("FAIL rst_addr got %h want 1234", imem_addr); end
        tick();
        checks++; if (fetch_stall_cycles !== 16'h0) begin errors++; $display("FAIL rst_cnt_hold got %h want 0", fetch_stall_cycles); end
        @(negedge clk);
        rst = 1'b0;
        // Asynchronous reset out of HOLD.
        drive(32'h8, 1'b1, 32'h5555, 1'b1, 1'b0);
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_entry_req got %b want 0", imem_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL async_rst_req got %b want 1", imem_req); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b want 0", if_id_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(32'(i * 4), 1'b1, 32'hA000_0000 + 32'(i * 4), 1'b0, 1'b0);
            #1;
            checks++; if (is_cache_missed !== 1'b0) begin errors++; $display("FAIL zw_miss[%0d] got %b want 0", i, is_cache_missed); end
            tick();
            checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d] got %b want 1", i, if_id_valid); end
            checks++; if (if_id_pc !== 32'(i * 4)) begin errors++; $display("FAIL zw_pc[%0d] got %h want %h", i, if_id_pc, i * 4); end
            checks++; if (if_id_instr !== 32'hA000_0000 + 32'(i * 4)) begin errors++; $display("FAIL zw_instr[%0d] got %h", i, if_id_instr); end
        end
        checks++; if (fetch_stall_cycles !== 16'h0) begin errors++; $display("FAIL zw_cnt got %h want 0", fetch_stall_cycles); end
    endtask

    task automatic test_miss_latency();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
            #1;
            checks++; if (is_cache_missed !== 1'b1) begin errors++; $display("FAIL ml_miss[%0d] got %b want 1", i, is_cache_missed); end
            checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL ml_addr[%0d] got %h want 10", i, imem_addr); end
            tick();
        end
        drive(32'h10, 1'b1, 32'hCAFE_0010, 1'b0, 1'b0);
        #1;
        checks++; if (is_cache_missed !== 1'b0) begin errors++; $display("FAIL ml_miss_ack got %b want 0", is_cache_missed); end
        tick();
        drive(32'h14, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (fetch_stall_cycles !== 16'd2) begin errors++; $display("FAIL ml_cnt got %0d want 2", fetch_stall_cycles); end
        checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL ml_valid got %b want 1", if_id_valid); end
        checks++; if (if_id_pc !== 32'h10) begin errors++; $display("FAIL ml_pc got %h want 10", if_id_pc); end
        checks++; if (if_id_pc_plus4 !== 32'h14) begin errors++; $display("FAIL ml_pc4 got %h want 14", if_id_pc_plus4); end
        checks++; if (if_id_instr !== 32'hCAFE_0010) begin errors++; $display("FAIL ml_instr got %h want cafe0010", if_id_instr); end
    endtask

    task automatic test_stall_on_ack();
        do_reset();
        drive(32'h1C, 1'b1, 32'h1111_001C, 1'b0, 1'b0);
        tick();
        drive(32'h20, 1'b1, 32'h2222_0020, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(32'h24, 1'b0, 32'h0, 1'b1, 1'b0);
            #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sa_req[%0d] got %b want 0", i, imem_req); end
            checks++; if (is_cache_missed !== 1'b0) begin errors++; $display("FAIL sa_miss[%0d] got %b want 0", i, is_cache_missed); end
            checks++; if (if_id_pc !== 32'h1C || if_id_instr !== 32'h1111_001C) begin
                errors++; $display("FAIL sa_hold[%0d] got %h/%h want 1c/1111001c", i, if_id_pc, if_id_instr); end
            tick();
        end
        drive(32'h24, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h20 || if_id_instr !== 32'h2222_0020) begin
            errors++; $display("FAIL sa_release got %b/%h/%h want 1/20/22220020", if_id_valid, if_id_pc, if_id_instr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL sa_back_fetch got %b want 1", imem_req); end
    endtask

    task automatic test_flush_outstanding();
        do_reset();
        drive(32'h3C, 1'b1, 32'h3333_003C, 1'b0, 1'b0);
        tick();
        drive(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(32'h40, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL fo_addr got %h want 40", imem_addr); end
        checks++; if (is_cache_missed !== 1'b1) begin errors++; $display("FAIL fo_miss got %b want 1", is_cache_missed); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL fo_valid got %b want 0", if_id_valid); end
        tick();
        drive(32'h100, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        #1;
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL fo_addr_ack got %h want 40", imem_addr); end
        tick();
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            errors++; $display("FAIL fo_discard got %b/%h want 0/0", if_id_valid, if_id_instr); end
        drive(32'h100, 1'b1, 32'h4444_0100, 1'b0, 1'b0);
        #1;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL fo_new_addr got %h want 100", imem_addr); end
        tick();
        checks++; if (if_id_pc !== 32'h100 || if_id_instr !== 32'h4444_0100) begin
            errors++; $display("FAIL fo_new_entry got %h/%h want 100/44440100", if_id_pc, if_id_instr); end
    endtask

    task automatic test_flush_ack_stall();
        do_reset();
        drive(32'h50, 1'b1, 32'h5555_0050, 1'b0, 1'b0);
        tick();
        drive(32'h54, 1'b1, 32'h6666_0054, 1'b1, 1'b1);
        tick();
        drive(32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            errors++; $display("FAIL fas_valid got %b/%h want 0/0", if_id_valid, if_id_instr); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("FAIL fas_state got %b/%h want 1/200", imem_req, imem_addr); end
        checks++; if (is_cache_missed !== 1'b1) begin errors++; $display("FAIL fas_miss got %b want 1", is_cache_missed); end
        tick();
    endtask

    task automatic test_wrap_saturation();
        do_reset();
        drive(32'hFFFF_FFFC, 1'b1, 32'h7777_7777, 1'b0, 1'b0);
        tick();
        checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want 0", if_id_pc_plus4); end
        checks++; if (if_id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h want fffffffc", if_id_pc); end
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        checks++; if (fetch_stall_cycles !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", fetch_stall_cycles); end
        repeat (70000 - 65534) @(posedge clk);
        #1;
        checks++; if (fetch_stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %h want ffff", fetch_stall_cycles); end
    endtask

    task automatic test_random();
        bit          m_valid, m_held, m_drop, miss_e, req_e;
        logic [31:0] m_pc, m_instr, m_hpc, m_hinstr, m_daddr, addr_e;
        int          m_cnt;
        logic        a, s, f;
        logic [31:0] p, d;
        do_reset();
        m_valid = 0; m_held = 0; m_drop = 0;
        m_pc = 0; m_instr = 0; m_hpc = 0; m_hinstr = 0; m_daddr = 0; m_cnt = 0;
        for (int n = 0; n < 2000; n++) begin
            checks++; if (if_id_valid !== m_valid || if_id_instr !== m_instr) begin
                errors++; $display("FAIL rnd_ifid[%0d] got %b/%h want %b/%h", n, if_id_valid, if_id_instr, m_valid, m_instr); end
            if (m_valid) begin
                checks++; if (if_id_pc !== m_pc || if_id_pc_plus4 !== m_pc + 32'd4) begin
                    errors++; $display("FAIL rnd_pc[%0d] got %h/%h want %h", n, if_id_pc, if_id_pc_plus4, m_pc); end
            end
            checks++; if (fetch_stall_cycles !== 16'(m_cnt)) begin
                errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", n, fetch_stall_cycles, m_cnt); end
            p = {$urandom_range(0, 255), 2'b00};
            p = {22'h0, p[9:0]};
            d = $urandom;
            s = ($urandom_range(0, 9) < 3);
            f = ($urandom_range(0, 9) == 0);
            a = !m_held && ($urandom_range(0, 1) == 1);
            drive(p, a, d, s, f);
            req_e  = !m_held;
            addr_e = m_drop ? m_daddr : p;
            miss_e = m_drop || (!m_held && !a);
            #1;
            checks++; if (imem_req !== req_e || is_cache_missed !== miss_e) begin
                errors++; $display("FAIL rnd_comb[%0d] req %b miss %b want %b %b", n, imem_req, is_cache_missed, req_e, miss_e); end
            if (req_e) begin
                checks++; if (imem_addr !== addr_e) begin
                    errors++; $display("FAIL rnd_addr[%0d] got %h want %h", n, imem_addr, addr_e); end
            end
            if (m_held) begin
                if (f) begin m_held = 0; m_valid = 0; m_instr = 0; end
                else if (!s) begin m_held = 0; m_valid = 1; m_pc = m_hpc; m_instr = m_hinstr; end
            end else if (m_drop) begin
                if (f) begin m_valid = 0; m_instr = 0; end
                if (a) m_drop = 0;
            end else if (f) begin
                m_valid = 0; m_instr = 0;
                if (!a) begin m_drop = 1; m_daddr = p; end
            end else if (a) begin
                if (!s) begin m_valid = 1; m_pc = p; m_instr = d; end
                else begin m_held = 1; m_hpc = p; m_hinstr = d; end
            end else if (!s) begin
                m_valid = 0; m_instr = 0;
            end
            if (miss_e && m_cnt < 65535) m_cnt++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_zero_wait();
        test_miss_latency();
        test_stall_on_ack();
        test_flush_outstanding();
        test_flush_ack_stall();
        test_random();
        test_wrap_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
